audio_sample_fifo: RTL and testbench

AUDIO_SAMPLE_FIFO -- requirements
Module: audio_sample_fifo

---
 rtl/audio_sample_fifo_if.sv | 31 +++
 rtl/audio_sample_fifo.sv | 92 +++++++++
 tb/tb_audio_sample_fifo.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/audio_sample_fifo_if.sv
// Producer/consumer bundle for the stereo audio sample FIFO.
// The FIFO takes the slave view; the driving agent takes the master view.
interface audio_sample_fifo_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned LvlW = $clog2(DEPTH) + 1;

  logic             enable;
  logic             audio_stb;
  logic [WIDTH-1:0] in_left;
  logic [WIDTH-1:0] in_right;
  logic             out_ready;
  logic             clear_ovf;
  logic             out_valid;
  logic [WIDTH-1:0] out_left;
  logic [WIDTH-1:0] out_right;
  logic [LvlW-1:0]  level;
  logic             overflow;
  logic [7:0]       drop_cnt;

  modport master (
    output enable, audio_stb, in_left, in_right, out_ready, clear_ovf,
    input  out_valid, out_left, out_right, level, overflow, drop_cnt
  );

  modport slave (
    input  enable, audio_stb, in_left, in_right, out_ready, clear_ovf,
    output out_valid, out_left, out_right, level, overflow, drop_cnt
  );
endinterface

// File: rtl/audio_sample_fifo.sv
// Stereo sample FIFO between the sample-rate strobe and the HDMI audio packet builder.
// Drops new samples when full (unless a pop frees a slot), with sticky overflow and drop count.
module audio_sample_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16
) (
  input logic               clk,
  input logic               reset,
  audio_sample_fifo_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] FullLvl = LvlW'(DEPTH);

  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]    level_q, level_d;
  logic               out_valid_q, out_valid_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;
  logic               full, push, pop, drop;
  logic [2*WIDTH-1:0] head;

  always_comb begin
    full = (level_q == FullLvl);
    pop  = out_valid_q & bus.out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the sample.
    push = bus.enable & bus.audio_stb & (~full | pop);
    drop = bus.enable & bus.audio_stb & full & ~pop;

    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
    out_valid_d = (level_d != '0);

    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (bus.clear_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
    // A drop coincident with a clear counts as the first drop after the clear.
    if (drop) begin
      overflow_d = 1'b1;
      if (bus.clear_ovf) begin
        drop_cnt_d = 8'd1;
      end else if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Storage is deliberately not reset; outputs are gated by out_valid instead.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.in_left, bus.in_right};
    end
  end

  assign head          = mem_q[rd_ptr_q];
  assign bus.out_valid = out_valid_q;
  assign bus.out_left  = out_valid_q ? head[2*WIDTH-1:WIDTH] : '0;
  assign bus.out_right = out_valid_q ? head[WIDTH-1:0] : '0;
  assign bus.level     = level_q;
  assign bus.overflow  = overflow_q;
  assign bus.drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed bench for audio_sample_fifo (DEPTH=8, WIDTH=16): vector table plus
// hand-written sequences for overflow, clear/drop collision, saturation and reset.
module tb_audio_sample_fifo;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  audio_sample_fifo_if #(.DEPTH(8), .WIDTH(16)) bus ();

  audio_sample_fifo #(.DEPTH(8), .WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        en;
    logic        stb;
    logic [15:0] l;
    logic [15:0] r;
    logic        rdy;
    logic        clr;
    logic        v;
    logic [15:0] el;
    logic [15:0] er;
    logic [3:0]  lvl;
    logic        ovf;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs [10];

  // {out_valid, out_left, out_right, level, overflow, drop_cnt}
  function automatic logic [45:0] snap();
    return {bus.out_valid, bus.out_left, bus.out_right, bus.level, bus.overflow, bus.drop_cnt};
  endfunction

  function automatic logic [45:0] pack(logic v, logic [15:0] l, logic [15:0] r,
                                       logic [3:0] lvl, logic ovf, logic [7:0] cnt);
    return {v, l, r, lvl, ovf, cnt};
  endfunction

  task automatic drive(logic en, logic stb, logic [15:0] l, logic [15:0] r,
                       logic rdy, logic clr);
    bus.enable    = en;
    bus.audio_stb = stb;
    bus.in_left   = l;
    bus.in_right  = r;
    bus.out_ready = rdy;
    bus.clear_ovf = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [45:0] exp);
    logic [45:0] got;
    got = snap();
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got v/L/R/lvl/ovf/cnt=%h expected %h", name, got, exp);
    end
  endtask

  initial begin
    //            en   stb  L        R        rdy  clr  v    L        R        lvl  ovf  cnt
    vecs[0] = '{1'b1, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, 16'h1111, 16'h2222, 4'd1, 1'b0, 8'd0};
    vecs[1] = '{1'b1, 1'b1, 16'h3333, 16'h4444, 1'b0, 1'b0, 1'b1, 16'h1111, 16'h2222, 4'd2, 1'b0, 8'd0};
    vecs[2] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1111, 16'h2222, 4'd2, 1'b0, 8'd0};
    vecs[3] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h3333, 16'h4444, 4'd1, 1'b0, 8'd0};
    vecs[4] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 8'd0};
    vecs[5] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 8'd0};
    vecs[6] = '{1'b0, 1'b1, 16'h5555, 16'h6666, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 8'd0};
    vecs[7] = '{1'b1, 1'b1, 16'h0001, 16'h1001, 1'b1, 1'b0, 1'b1, 16'h0001, 16'h1001, 4'd1, 1'b0, 8'd0};
    vecs[8] = '{1'b1, 1'b1, 16'h0002, 16'h1002, 1'b1, 1'b0, 1'b1, 16'h0002, 16'h1002, 4'd1, 1'b0, 8'd0};
    vecs[9] = '{1'b0, 1'b1, 16'h0003, 16'h1003, 1'b0, 1'b0, 1'b1, 16'h0002, 16'h1002, 4'd1, 1'b0, 8'd0};

    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick();
    tick();
    check("reset_state", pack(1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 8'd0));
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].en, vecs[i].stb, vecs[i].l, vecs[i].r, vecs[i].rdy, vecs[i].clr);
      tick();
      check($sformatf("vec%0d", i), pack(vecs[i].v, vecs[i].el, vecs[i].er, vecs[i].lvl,
                                         vecs[i].ovf, vecs[i].cnt));
    end

    // Overflow: 10 strobes into an empty FIFO, nothing consumed.
    reset = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 1'b1, 16'(i), 16'(16'h100 + i), 1'b0, 1'b0);
      tick();
    end
    check("ovf_fill", pack(1'b1, 16'h0001, 16'h0101, 4'd8, 1'b1, 8'd2));

    // Full with simultaneous write and pop.
    drive(1'b1, 1'b1, 16'h000B, 16'h010B, 1'b1, 1'b0);
    tick();
    check("full_wr_pop", pack(1'b1, 16'h0002, 16'h0102, 4'd8, 1'b1, 8'd2));

    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    for (int k = 2; k <= 8; k++) begin
      check($sformatf("drain%0d", k), pack(1'b1, 16'(k), 16'(16'h100 + k), 4'(10 - k),
                                           1'b1, 8'd2));
      tick();
    end
    check("drain_last", pack(1'b1, 16'h000B, 16'h010B, 4'd1, 1'b1, 8'd2));
    tick();
    check("drain_empty", pack(1'b0, 16'h0, 16'h0, 4'd0, 1'b1, 8'd2));

    // Clear, refill, then clear colliding with a drop.
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    tick();
    check("clear_only", pack(1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 8'd0));
    for (int i = 1; i <= 9; i++) begin
      drive(1'b1, 1'b1, 16'(16'h20 + i), 16'(16'h120 + i), 1'b0, 1'b0);
      tick();
    end
    check("refill_drop", pack(1'b1, 16'h0021, 16'h0121, 4'd8, 1'b1, 8'd1));
    drive(1'b1, 1'b1, 16'h0099, 16'h0199, 1'b0, 1'b1);
    tick();
    check("clear_vs_drop", pack(1'b1, 16'h0021, 16'h0121, 4'd8, 1'b1, 8'd1));
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    tick();
    check("clear_after", pack(1'b1, 16'h0021, 16'h0121, 4'd8, 1'b0, 8'd0));

    // Drop counter saturation.
    drive(1'b1, 1'b1, 16'h0077, 16'h0177, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) tick();
    check("drop_sat", pack(1'b1, 16'h0021, 16'h0121, 4'd8, 1'b1, 8'd255));
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    tick();

    // Strobes while disabled: no writes, no drops.
    drive(1'b0, 1'b1, 16'h0055, 16'h0155, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    check("disabled", pack(1'b1, 16'h0021, 16'h0121, 4'd8, 1'b0, 8'd0));

    // Reset mid-operation at level 5.
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    check("pre_reset", pack(1'b1, 16'h0024, 16'h0124, 4'd5, 1'b0, 8'd0));
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("async_reset", pack(1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 8'd0));
    tick();
    check("in_reset", pack(1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 8'd0));
    reset = 1'b0;
    drive(1'b1, 1'b1, 16'hABCD, 16'h1234, 1'b0, 1'b0);
    tick();
    check("post_reset", pack(1'b1, 16'hABCD, 16'h1234, 4'd1, 1'b0, 8'd0));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
